// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers operands, S2 computes and registers result + flags.
// Valid/ready on both sides with full throughput; counts results accepted downstream.
module alu_pipe #(
   parameter int DWIDTH = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        sel_i,
   input  logic [DWIDTH-1:0] op1_i,
   input  logic [DWIDTH-1:0] op2_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DWIDTH-1:0] res_o,
   output logic              zero_o,
   output logic              neg_o,
   output logic              carry_o,
   output logic              ovf_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  ops_done_o
);
   localparam int SW  = $clog2(DWIDTH);
   localparam int MSB = DWIDTH - 1;

   logic              s1_valid_q, s2_valid_q;
   logic [3:0]        s1_sel_q;
   logic [DWIDTH-1:0] s1_a_q, s1_b_q;
   logic [DWIDTH-1:0] res_q, res_d;
   logic              zero_q, neg_q, carry_q, ovf_q, ill_q;
   logic              carry_d, ovf_d, ill_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              s2_adv, s1_adv;
   logic [DWIDTH:0]   sum, diff;
   logic [DWIDTH-1:0] bneg;
   logic [SW-1:0]     sh;

   assign s2_adv     = !s2_valid_q || out_ready_i;
   assign s1_adv     = s1_valid_q && s2_adv;
   assign in_ready_o = !s1_valid_q || s2_adv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
      end else if (in_ready_o) begin
         s1_valid_q <= in_valid_i;
      end
   end

   // Operand registers carry no reset; their contents only matter when s1_valid_q is set.
   always_ff @(posedge clk) begin
      if (in_valid_i && in_ready_o) begin
         s1_sel_q <= sel_i;
         s1_a_q   <= op1_i;
         s1_b_q   <= op2_i;
      end
   end

   assign sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
   assign diff = {1'b0, s1_a_q} - {1'b0, s1_b_q};
   assign bneg = ~s1_b_q + 1'b1;
   assign sh   = s1_b_q[SW-1:0];

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
      case (s1_sel_q)
         4'd0: begin
            res_d   = sum[MSB:0];
            carry_d = sum[DWIDTH];
            ovf_d   = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
         end
         4'd1: begin
            res_d   = diff[MSB:0];
            carry_d = diff[DWIDTH];
            ovf_d   = (s1_a_q[MSB] == bneg[MSB]) && (diff[MSB] != s1_a_q[MSB]);
         end
         4'd2: res_d = s1_a_q & s1_b_q;
         4'd3: res_d = s1_a_q | s1_b_q;
         4'd4: res_d = s1_a_q ^ s1_b_q;
         4'd5: res_d = s1_a_q << sh;
         4'd6: res_d = s1_a_q >> sh;
         4'd7: res_d = $unsigned($signed(s1_a_q) >>> sh);
         4'd8: res_d = DWIDTH'($signed(s1_a_q) < $signed(s1_b_q));
         4'd9: res_d = DWIDTH'(s1_a_q < s1_b_q);
         default: ill_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         zero_q     <= 1'b1;
         neg_q      <= 1'b0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_adv) begin
            res_q   <= res_d;
            zero_q  <= (res_d == '0);
            neg_q   <= res_d[MSB];
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (s2_valid_q && out_ready_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_valid_o = s2_valid_q;
   assign res_o       = res_q;
   assign zero_o      = zero_q;
   assign neg_o       = neg_q;
   assign carry_o     = carry_q;
   assign ovf_o       = ovf_q;
   assign illegal_o   = ill_q;
   assign ops_done_o  = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at DWIDTH=8, CNT_W=4: op table, streaming, stall and reset sequences.
module tb_alu_pipe;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [3:0] sel_i;
   logic [7:0] op1_i, op2_i, res_o;
   logic       zero_o, neg_o, carry_o, ovf_o, illegal_o;
   logic [3:0] ops_done_o;

   int checks = 0;
   int errors = 0;

   alu_pipe #(.DWIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .sel_i(sel_i), .op1_i(op1_i), .op2_i(op2_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .res_o(res_o), .zero_o(zero_o), .neg_o(neg_o), .carry_o(carry_o),
      .ovf_o(ovf_o), .illegal_o(illegal_o), .ops_done_o(ops_done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sel;
      logic [7:0] a, b, res;
      logic [4:0] flg;   // {zero, neg, carry, ovf, illegal}
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   logic [3:0] rs[20];
   logic [7:0] ra[20], rb[20];

   initial begin
      vecs[0]  = '{4'd0, 8'h7F, 8'h01, 8'h80, 5'b01010};
      vecs[1]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 5'b10100};
      vecs[2]  = '{4'd1, 8'h00, 8'h01, 8'hFF, 5'b01100};
      vecs[3]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 5'b00010};
      vecs[4]  = '{4'd8, 8'hFF, 8'h01, 8'h01, 5'b00000};
      vecs[5]  = '{4'd9, 8'hFF, 8'h01, 8'h00, 5'b10000};
      vecs[6]  = '{4'd5, 8'h01, 8'h0B, 8'h08, 5'b00000};
      vecs[7]  = '{4'd7, 8'h80, 8'h07, 8'hFF, 5'b01000};
      vecs[8]  = '{4'd6, 8'h80, 8'h07, 8'h01, 5'b00000};
      vecs[9]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 5'b00000};
      vecs[10] = '{4'd3, 8'hF0, 8'h0F, 8'hFF, 5'b01000};
      vecs[11] = '{4'd4, 8'hFF, 8'hFF, 8'h00, 5'b10000};
      vecs[12] = '{4'd12, 8'h12, 8'h34, 8'h00, 5'b10001};
      vecs[13] = '{4'd1, 8'h05, 8'h05, 8'h00, 5'b10000};
      vecs[14] = '{4'd9, 8'h01, 8'hFF, 8'h01, 5'b00000};

      rst = 1'b0;
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      sel_i = '0; op1_i = '0; op2_i = '0;
      #12;
      chk("rst out_valid", out_valid_o, 0);
      chk("rst in_ready", in_ready_o, 1);
      chk("rst res", res_o, 0);
      chk("rst flags", {zero_o, neg_o, carry_o, ovf_o, illegal_o}, 5'b10000);
      chk("rst ops_done", ops_done_o, 0);
      @(negedge clk) rst = 1'b1;
      step();

      // 20 back-to-back beats, one result per cycle, in order
      for (int i = 0; i < 20; i++) begin
         rs[i] = 4'($urandom_range(0, 4));
         ra[i] = 8'($urandom);
         rb[i] = 8'($urandom);
      end
      for (int i = 0; i < 22; i++) begin
         if (i >= 2) begin
            chk("stream valid", out_valid_o, 1);
            chk("stream res", res_o, model(rs[i-2], ra[i-2], rb[i-2]));
         end
         chk("stream in_ready", in_ready_o, 1);
         if (i < 20) begin
            in_valid_i = 1'b1; sel_i = rs[i]; op1_i = ra[i]; op2_i = rb[i];
         end else begin
            in_valid_i = 1'b0;
         end
         step();
      end
      step();
      chk("stream drained", out_valid_o, 0);
      chk("stream ops_done", ops_done_o, 4);

      // stall: 3 beats offered while downstream blocks
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; sel_i = 4'd0; op1_i = 8'h01; op2_i = 8'h10;
      chk("stall rdy0", in_ready_o, 1);
      step();
      op1_i = 8'h02;
      chk("stall rdy1", in_ready_o, 1);
      step();
      op1_i = 8'h03;
      for (int k = 0; k < 4; k++) begin
         chk("stall in_ready low", in_ready_o, 0);
         chk("stall valid held", out_valid_o, 1);
         chk("stall res held", res_o, 8'h11);
         if (k < 3) step();
      end
      out_ready_i = 1'b1;
      #1;
      chk("stall release in_ready", in_ready_o, 1);
      step();
      in_valid_i = 1'b0;
      chk("stall res B", res_o, 8'h12);
      chk("stall valid B", out_valid_o, 1);
      step();
      chk("stall res C", res_o, 8'h13);
      chk("stall valid C", out_valid_o, 1);
      step();
      chk("stall drained", out_valid_o, 0);
      chk("stall ops_done", ops_done_o, 7);

      // op table, one beat at a time
      foreach (vecs[i]) begin
         in_valid_i = 1'b1; sel_i = vecs[i].sel; op1_i = vecs[i].a; op2_i = vecs[i].b;
         step();
         in_valid_i = 1'b0;
         chk("vec early valid", out_valid_o, 0);
         step();
         chk($sformatf("vec%0d valid", i), out_valid_o, 1);
         chk($sformatf("vec%0d res", i), res_o, vecs[i].res);
         chk($sformatf("vec%0d flags", i), {zero_o, neg_o, carry_o, ovf_o, illegal_o}, vecs[i].flg);
      end
      step();
      chk("table ops_done wrap", ops_done_o, 4'd6);

      // reset with two beats in flight
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; sel_i = 4'd0; op1_i = 8'h21; op2_i = 8'h01;
      step();
      op1_i = 8'h31;
      step();
      in_valid_i = 1'b0;
      chk("pre-rst valid", out_valid_o, 1);
      rst = 1'b0;
      #1;
      chk("mid rst valid", out_valid_o, 0);
      chk("mid rst res", res_o, 0);
      chk("mid rst zero", zero_o, 1);
      chk("mid rst ops_done", ops_done_o, 0);
      chk("mid rst in_ready", in_ready_o, 1);
      @(negedge clk) rst = 1'b1;
      out_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("post rst no valid", out_valid_o, 0);
      end
      chk("post rst ops_done", ops_done_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
